ysyx_idu_stage: RTL and testbench

//  Registered, handshaked decode stage between IFU and EXU. Decodes RV32I base ops
//  (addi, add, sub, lui, auipc, jal, jalr, lw, sw, ebreak) into control signals.

---
 rtl/ysyx_idu_stage.sv | 206 ++++++++++++++++++++
 tb/tb_ysyx_idu_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_idu_stage.sv
// ysyx_idu_stage
//   Registered, handshaked RV32I decode stage sitting between IFU and EXU.
//   Decodes addi, add, sub, lui, auipc, jal, jalr, lw, sw and ebreak into a
//   control bundle. The stage holds one bundle with a latency of one cycle.
//   A halting bundle (ebreak, or an illegal op when HALT_ON_ILLEGAL=1) parks
//   the stage in HALT until a flush or reset arrives.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   in_valid/in_ready      IFU handshake; inst, pc presented with in_valid
//   flush                  drop the held bundle, refuse input, leave HALT
//   out_valid/out_ready    EXU handshake for the decoded bundle
//   out_pc, rs1, rs2, rd   pc and register indices of the held instruction
//   imm                    sign-extended immediate (0 for R-type)
//   rf_wr_en, rf_wr_sel    rd write enable / source (00 ALU, 01 pc+4, 10 mem)
//   do_jump                jal/jalr
//   alu_a_sel, alu_b_sel   a: 1 rs1 / 0 pc; b: 1 imm / 0 rs2
//   alu_ctrl               0000 add, 1000 sub, 1110 pass-B
//   mem_rd_en, mem_wr_en   lw / sw
//   illegal, halt          only asserted while out_valid is high
//
// state  | meaning
// S_RUN  | normal flow; input accepted whenever the output slot frees up
// S_HALT | halting bundle taken; input refused until flush or reset
module ysyx_idu_stage #(
    parameter int XLEN            = 32,
    parameter int ALU_CTRL_W      = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           inst,
    input  logic [XLEN-1:0]       pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [XLEN-1:0]       imm,
    output logic                  rf_wr_en,
    output logic [1:0]            rf_wr_sel,
    output logic                  do_jump,
    output logic                  alu_a_sel,
    output logic                  alu_b_sel,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic                  illegal,
    output logic                  halt
);

    typedef enum logic {S_RUN, S_HALT} state_t;
    state_t state;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_u, imm_j, imm_32;

    logic                  d_wr_en;
    logic [1:0]            d_wr_sel;
    logic                  d_jump;
    logic                  d_a_sel;
    logic                  d_b_sel;
    logic [ALU_CTRL_W-1:0] d_alu;
    logic                  d_mem_rd;
    logic                  d_mem_wr;
    logic                  d_illegal;
    logic                  d_ebreak;
    logic                  d_halt;
    logic                  accept;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        d_wr_en   = 1'b0;
        d_wr_sel  = 2'b00;
        d_jump    = 1'b0;
        d_a_sel   = 1'b1;
        d_b_sel   = 1'b1;
        d_alu     = '0;
        d_mem_rd  = 1'b0;
        d_mem_wr  = 1'b0;
        d_illegal = 1'b0;
        d_ebreak  = 1'b0;
        imm_32    = '0;
        if (inst == 32'h0010_0073) begin
            d_ebreak = 1'b1;
        end else begin
            case (opcode)
                7'h13: if (funct3 == 3'd0) begin
                           d_wr_en = 1'b1;
                           imm_32  = imm_i;
                       end else d_illegal = 1'b1;
                7'h33: if (funct3 == 3'd0 && (funct7 == 7'h00 || funct7 == 7'h20)) begin
                           d_wr_en = 1'b1;
                           d_b_sel = 1'b0;
                           d_alu   = (funct7 == 7'h20) ? ALU_CTRL_W'(4'b1000) : '0;
                       end else d_illegal = 1'b1;
                7'h37: begin
                           d_wr_en = 1'b1;
                           d_alu   = ALU_CTRL_W'(4'b1110);
                           imm_32  = imm_u;
                       end
                7'h17: begin
                           d_wr_en = 1'b1;
                           d_a_sel = 1'b0;
                           imm_32  = imm_u;
                       end
                7'h6f: begin
                           d_wr_en  = 1'b1;
                           d_wr_sel = 2'b01;
                           d_jump   = 1'b1;
                           d_a_sel  = 1'b0;
                           imm_32   = imm_j;
                       end
                7'h67: if (funct3 == 3'd0) begin
                           d_wr_en  = 1'b1;
                           d_wr_sel = 2'b01;
                           d_jump   = 1'b1;
                           imm_32   = imm_i;
                       end else d_illegal = 1'b1;
                7'h03: if (funct3 == 3'd2) begin
                           d_wr_en  = 1'b1;
                           d_wr_sel = 2'b10;
                           d_mem_rd = 1'b1;
                           imm_32   = imm_i;
                       end else d_illegal = 1'b1;
                7'h23: if (funct3 == 3'd2) begin
                           d_mem_wr = 1'b1;
                           imm_32   = imm_s;
                       end else d_illegal = 1'b1;
                default: d_illegal = 1'b1;
            endcase
        end
        // x0 is never written, whatever the opcode asks for
        if (inst[11:7] == 5'd0) d_wr_en = 1'b0;
    end

    assign d_halt   = d_ebreak | (d_illegal & HALT_ON_ILLEGAL);
    assign in_ready = (state == S_RUN) & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            out_valid <= 1'b0;
            out_pc    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            imm       <= '0;
            rf_wr_en  <= 1'b0;
            rf_wr_sel <= '0;
            do_jump   <= 1'b0;
            alu_a_sel <= 1'b0;
            alu_b_sel <= 1'b0;
            alu_ctrl  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            illegal   <= 1'b0;
            halt      <= 1'b0;
        end else if (flush) begin
            // a redirect past ebreak is legal, so flush also releases HALT
            state     <= S_RUN;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            halt      <= 1'b0;
        end else if (accept) begin
            if (d_halt) state <= S_HALT;
            out_valid <= 1'b1;
            out_pc    <= pc;
            rs1       <= inst[19:15];
            rs2       <= inst[24:20];
            rd        <= inst[11:7];
            imm       <= XLEN'($signed(imm_32));
            rf_wr_en  <= d_wr_en;
            rf_wr_sel <= d_wr_sel;
            do_jump   <= d_jump;
            alu_a_sel <= d_a_sel;
            alu_b_sel <= d_b_sel;
            alu_ctrl  <= d_alu;
            mem_rd_en <= d_mem_rd;
            mem_wr_en <= d_mem_wr;
            illegal   <= d_illegal;
            halt      <= d_halt;
        end else if (out_ready) begin
            // bundle consumed with nothing behind it; flags must not outlive out_valid
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            halt      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_idu_stage.sv
module tb_ysyx_idu_stage;

    localparam bit HOI = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        rf_wr_en;
    logic [1:0]  rf_wr_sel;
    logic        do_jump, alu_a_sel, alu_b_sel;
    logic [3:0]  alu_ctrl;
    logic        mem_rd_en, mem_wr_en, illegal, halt;

    ysyx_idu_stage #(.XLEN(32), .ALU_CTRL_W(4), .HALT_ON_ILLEGAL(HOI)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .do_jump(do_jump),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .illegal(illegal), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        wr;
        logic [1:0]  sel;
        logic        jump, a_sel, b_sel;
        logic [3:0]  alu;
        logic        mrd, mwr, ill, hlt, alu_known;
    } bundle_t;

    int      n_checks = 0;
    int      n_errors = 0;
    bundle_t held;
    bit      mv;
    bit      halted;
    bit      full;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode, written from the ISA field definitions.
    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] p);
        bundle_t     b;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          i_imm, s_imm, u_imm, j_imm;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        i_imm = $signed(w) >>> 20;
        s_imm = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
        u_imm = int'(w & 32'hFFFF_F000);
        j_imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                + int'(w[30:21]) * 2;
        b = '0;
        b.pc = p;
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        b.rd  = w[11:7];
        b.a_sel = 1'b1;
        b.b_sel = 1'b1;
        b.alu_known = 1'b1;
        if (w == 32'h0010_0073) begin
            b.hlt = 1'b1;
            b.alu_known = 1'b0;
        end else if (op == 7'h13 && f3 == 0) begin
            b.imm = i_imm; b.wr = 1;
        end else if (op == 7'h33 && f3 == 0 && (f7 == 0 || f7 == 7'h20)) begin
            b.b_sel = 0; b.wr = 1; b.alu = (f7 == 7'h20) ? 4'b1000 : 4'b0000;
        end else if (op == 7'h37) begin
            b.imm = u_imm; b.wr = 1; b.alu = 4'b1110;
        end else if (op == 7'h17) begin
            b.imm = u_imm; b.wr = 1; b.a_sel = 0;
        end else if (op == 7'h6f) begin
            b.imm = j_imm; b.wr = 1; b.a_sel = 0; b.jump = 1; b.sel = 2'b01;
        end else if (op == 7'h67 && f3 == 0) begin
            b.imm = i_imm; b.wr = 1; b.jump = 1; b.sel = 2'b01;
        end else if (op == 7'h03 && f3 == 2) begin
            b.imm = i_imm; b.wr = 1; b.mrd = 1; b.sel = 2'b10;
        end else if (op == 7'h23 && f3 == 2) begin
            b.imm = s_imm; b.mwr = 1;
        end else begin
            b.ill = 1; b.hlt = HOI; b.alu_known = 0;
        end
        if (b.rd == 0) b.wr = 0;
        return b;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  return {r[31:15], 3'd0, r[11:7], 7'h13};
            1:  return {7'h00, r[24:15], 3'd0, r[11:7], 7'h33};
            2:  return {7'h20, r[24:15], 3'd0, r[11:7], 7'h33};
            3:  return {r[31:7], 7'h37};
            4:  return {r[31:7], 7'h17};
            5:  return {r[31:7], 7'h6f};
            6:  return {r[31:15], 3'd0, r[11:7], 7'h67};
            7:  return {r[31:15], 3'd2, r[11:7], 7'h03};
            8:  return {r[31:15], 3'd2, r[11:7], 7'h23};
            9:  return 32'h0010_0073;
            10: return r;
            default: return {7'h01, r[24:15], 3'd0, r[11:7], 7'h33};
        endcase
    endfunction

    // One clock: check in_ready against the model, advance the model on the
    // edge, then compare the registered bundle.
    task automatic tick();
        bit exp_rdy;
        exp_rdy = !halted && !flush && (!mv || out_ready);
        #1;
        if (!rst) check_eq("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (rst) begin
            mv = 0; halted = 0; held = '0; full = 1;
        end else if (flush) begin
            mv = 0; halted = 0;
        end else if (in_valid && exp_rdy) begin
            held = ref_decode(inst, pc);
            mv = 1; full = 0;
            if (held.hlt) halted = 1;
        end else if (out_ready) begin
            mv = 0;
        end
        #1;
        check_eq("out_valid", out_valid, mv);
        check_eq("halt", halt, mv & held.hlt);
        check_eq("illegal", illegal, mv & held.ill);
        if (mv || full) begin
            check_eq("out_pc", out_pc, held.pc);
            check_eq("rs1", rs1, held.rs1);
            check_eq("rs2", rs2, held.rs2);
            check_eq("rd", rd, held.rd);
            check_eq("rf_wr_en", rf_wr_en, held.wr);
            check_eq("do_jump", do_jump, held.jump);
            check_eq("mem_rd_en", mem_rd_en, held.mrd);
            check_eq("mem_wr_en", mem_wr_en, held.mwr);
            if (held.alu_known || full) begin
                check_eq("imm", imm, held.imm);
                check_eq("rf_wr_sel", rf_wr_sel, held.sel);
                check_eq("alu_a_sel", alu_a_sel, held.a_sel);
                check_eq("alu_b_sel", alu_b_sel, held.b_sel);
                check_eq("alu_ctrl", alu_ctrl, held.alu);
            end
        end
    endtask

    task automatic present(input logic [31:0] w, input logic [31:0] p);
        in_valid = 1; inst = w; pc = p;
    endtask

    initial begin
        rst = 1; in_valid = 0; inst = 0; pc = 0; flush = 0; out_ready = 0;
        mv = 0; halted = 0; held = '0; full = 0;
        tick(); tick();
        rst = 0;

        // addi x1,x0,5
        out_ready = 1;
        present(32'h0050_0093, 32'h100);
        tick();
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_rd", rd, 1);
        check_eq("t1_imm", imm, 5);
        check_eq("t1_wr", rf_wr_en, 1);
        check_eq("t1_alu", alu_ctrl, 0);
        check_eq("t1_bsel", alu_b_sel, 1);
        check_eq("t1_wsel", rf_wr_sel, 0);
        in_valid = 0;
        tick();

        // lui / jal / sw back-to-back
        present(32'h1234_5137, 32'h200);
        tick();
        check_eq("t2_lui_imm", imm, 32'h1234_5000);
        check_eq("t2_lui_alu", alu_ctrl, 4'b1110);
        present(32'h0080_00EF, 32'h204);
        tick();
        check_eq("t2_jal_valid", out_valid, 1);
        check_eq("t2_jal_jump", do_jump, 1);
        check_eq("t2_jal_wsel", rf_wr_sel, 2'b01);
        check_eq("t2_jal_imm", imm, 8);
        present(32'h0020_A223, 32'h208);
        tick();
        check_eq("t2_sw_valid", out_valid, 1);
        check_eq("t2_sw_mwr", mem_wr_en, 1);
        check_eq("t2_sw_wr", rf_wr_en, 0);
        check_eq("t2_sw_imm", imm, 4);
        in_valid = 0;
        tick();

        // backpressure
        present(32'h0050_0093, 32'h300);
        tick();
        out_ready = 0;
        present(32'h4020_81B3, 32'h304);
        repeat (4) begin
            tick();
            check_eq("t3_pc_stable", out_pc, 32'h300);
        end
        out_ready = 1;
        tick();
        check_eq("t3_next_pc", out_pc, 32'h304);
        check_eq("t3_sub", alu_ctrl, 4'b1000);
        in_valid = 0;
        tick();

        // ebreak then halt until flush
        present(32'h0010_0073, 32'h400);
        tick();
        check_eq("t4_halt", halt, 1);
        present(32'h0050_0093, 32'h404);
        repeat (3) tick();
        check_eq("t4_halted_idle", out_valid, 0);
        flush = 1;
        tick();
        flush = 0;
        tick();
        check_eq("t4_resume_pc", out_pc, 32'h404);
        in_valid = 0;
        tick();

        // flush under backpressure
        out_ready = 0;
        present(32'h0050_0093, 32'h500);
        tick();
        present(32'h0070_0113, 32'h504);
        flush = 1;
        tick();
        check_eq("t5_flushed", out_valid, 0);
        flush = 0;
        tick();
        check_eq("t5_not_consumed_pc", out_pc, 32'h504);
        out_ready = 1;
        in_valid = 0;
        tick();

        // all-ones word is illegal
        present(32'hFFFF_FFFF, 32'h600);
        tick();
        check_eq("t6_illegal", illegal, 1);
        check_eq("t6_halt", halt, HOI);
        in_valid = 0;
        flush = 1;
        tick();
        flush = 0;

        // reset while a bundle is held
        out_ready = 0;
        present(32'h0050_0093, 32'h700);
        tick();
        rst = 1;
        tick();
        rst = 0;
        in_valid = 0;
        tick();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            inst      = gen_inst();
            pc        = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
